// File: rtl/axilite_slave_shim.sv
// AXI4-Lite slave that turns one buffered AW/W or AR into a single-beat local
// MMIO request pulse and maps the local ack/dv (or a timeout) onto B/R responses.
module axilite_slave_shim #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        lcl_mmio_wr,
  output logic        lcl_mmio_rd,
  output logic [31:0] lcl_mmio_addr,
  output logic [31:0] lcl_mmio_din,
  output logic [3:0]  lcl_mmio_be,
  input  logic        lcl_mmio_ack,
  input  logic        lcl_mmio_dv,
  input  logic [31:0] lcl_mmio_dout,
  input  logic        lcl_mmio_rsp
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_RESP = 3'd4
  } state_e;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
  localparam logic [1:0]  RESP_OK   = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b10;

  state_e      state_q, state_d;
  logic        aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic        awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        last_wr_q, last_wr_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        lcl_wr_q, lcl_wr_d, lcl_rd_q, lcl_rd_d;
  logic [31:0] lcl_addr_q, lcl_addr_d, lcl_din_q, lcl_din_d;
  logic [3:0]  lcl_be_q, lcl_be_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        launch_wr_s, launch_rd_s;
  logic        wr_rdy_s, rd_rdy_s;
  logic        unused_prot;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};
  assign wr_rdy_s    = aw_full_q & w_full_q;
  assign rd_rdy_s    = ar_full_q;

  // Holding buffers: a launch empties a buffer in the same edge that it would refill it.
  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    ar_full_d = ar_full_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    if (launch_wr_s) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (s_axi_awvalid && awready_q) begin
        aw_full_d = 1'b1;
        awaddr_d  = s_axi_awaddr;
      end else begin
        aw_full_d = aw_full_q;
      end
      if (s_axi_wvalid && wready_q) begin
        w_full_d = 1'b1;
        wdata_d  = s_axi_wdata;
        wstrb_d  = s_axi_wstrb;
      end else begin
        w_full_d = w_full_q;
      end
    end
    if (launch_rd_s) begin
      ar_full_d = 1'b0;
    end else if (s_axi_arvalid && arready_q) begin
      ar_full_d = 1'b1;
      araddr_d  = s_axi_araddr;
    end else begin
      ar_full_d = ar_full_q;
    end
    awready_d = ~aw_full_d;
    wready_d  = ~w_full_d;
    arready_d = ~ar_full_d;
  end

  // Transaction FSM: arbitration, request launch, ack/timeout capture, response hold.
  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    tmo_cnt_d   = tmo_cnt_q;
    lcl_wr_d    = 1'b0;
    lcl_rd_d    = 1'b0;
    lcl_addr_d  = lcl_addr_q;
    lcl_din_d   = lcl_din_q;
    lcl_be_d    = lcl_be_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    rvalid_d    = rvalid_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    launch_wr_s = 1'b0;
    launch_rd_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Both ready: serve the opposite of whatever went last.
        if (wr_rdy_s && (!rd_rdy_s || !last_wr_q)) begin
          launch_wr_s = 1'b1;
          lcl_wr_d    = 1'b1;
          lcl_addr_d  = awaddr_q;
          lcl_din_d   = wdata_q;
          lcl_be_d    = wstrb_q;
          tmo_cnt_d   = 16'd0;
          last_wr_d   = 1'b1;
          state_d     = ST_WR_WAIT;
        end else if (rd_rdy_s) begin
          launch_rd_s = 1'b1;
          lcl_rd_d    = 1'b1;
          lcl_addr_d  = araddr_q;
          tmo_cnt_d   = 16'd0;
          last_wr_d   = 1'b0;
          state_d     = ST_RD_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (lcl_mmio_ack) begin
          bresp_d  = lcl_mmio_rsp ? RESP_OK : RESP_ERR;
          bvalid_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          bresp_d  = RESP_ERR;
          bvalid_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_WR_RESP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (lcl_mmio_dv) begin
          rdata_d  = lcl_mmio_dout;
          rresp_d  = lcl_mmio_rsp ? RESP_OK : RESP_ERR;
          rvalid_d = 1'b1;
          state_d  = ST_RD_RESP;
        end else if (tmo_cnt_q == TMO_LIMIT) begin
          rdata_d  = ERR_DATA;
          rresp_d  = RESP_ERR;
          rvalid_d = 1'b1;
          state_d  = ST_RD_RESP;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_RESP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        bvalid_d = 1'b0;
        rvalid_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      aw_full_q  <= 1'b0;
      w_full_q   <= 1'b0;
      ar_full_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      arready_q  <= 1'b0;
      awaddr_q   <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      araddr_q   <= 32'd0;
      last_wr_q  <= 1'b0;
      tmo_cnt_q  <= 16'd0;
      lcl_wr_q   <= 1'b0;
      lcl_rd_q   <= 1'b0;
      lcl_addr_q <= 32'd0;
      lcl_din_q  <= 32'd0;
      lcl_be_q   <= 4'd0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'd0;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      aw_full_q  <= aw_full_d;
      w_full_q   <= w_full_d;
      ar_full_q  <= ar_full_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      arready_q  <= arready_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      araddr_q   <= araddr_d;
      last_wr_q  <= last_wr_d;
      tmo_cnt_q  <= tmo_cnt_d;
      lcl_wr_q   <= lcl_wr_d;
      lcl_rd_q   <= lcl_rd_d;
      lcl_addr_q <= lcl_addr_d;
      lcl_din_q  <= lcl_din_d;
      lcl_be_q   <= lcl_be_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign lcl_mmio_wr   = lcl_wr_q;
  assign lcl_mmio_rd   = lcl_rd_q;
  assign lcl_mmio_addr = lcl_addr_q;
  assign lcl_mmio_din  = lcl_din_q;
  assign lcl_mmio_be   = lcl_be_q;

endmodule

// File: tb/tb_axilite_slave_shim.sv
// Directed bench for axilite_slave_shim: latency, stalls, error/timeout paths,
// read/write alternation and mid-transaction reset.
module tb_axilite_slave_shim;

  logic        clk;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awprot;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arprot;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        lcl_mmio_wr, lcl_mmio_rd;
  logic [31:0] lcl_mmio_addr, lcl_mmio_din;
  logic [3:0]  lcl_mmio_be;
  logic        lcl_mmio_ack, lcl_mmio_dv;
  logic [31:0] lcl_mmio_dout;
  logic        lcl_mmio_rsp;

  int n_tests = 0;
  int n_fail  = 0;

  axilite_slave_shim #(.TIMEOUT(8), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .lcl_mmio_wr(lcl_mmio_wr), .lcl_mmio_rd(lcl_mmio_rd),
    .lcl_mmio_addr(lcl_mmio_addr), .lcl_mmio_din(lcl_mmio_din), .lcl_mmio_be(lcl_mmio_be),
    .lcl_mmio_ack(lcl_mmio_ack), .lcl_mmio_dv(lcl_mmio_dv),
    .lcl_mmio_dout(lcl_mmio_dout), .lcl_mmio_rsp(lcl_mmio_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_axi_awvalid = 1'b0; s_axi_awaddr = 32'd0; s_axi_awprot = 3'd0;
    s_axi_wvalid = 1'b0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0;
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = 32'd0; s_axi_arprot = 3'd0;
    s_axi_rready = 1'b0;
    lcl_mmio_ack = 1'b0; lcl_mmio_dv = 1'b0; lcl_mmio_dout = 32'd0; lcl_mmio_rsp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Waits for the next request pulse, answers it one cycle later and completes the response.
  task automatic serve(output int kind);
    kind = 0;
    for (int i = 0; i < 20 && kind == 0; i++) begin
      if (lcl_mmio_wr) kind = 1;
      else if (lcl_mmio_rd) kind = 2;
      else tick();
    end
    if (kind != 0) begin
      tick();
      lcl_mmio_rsp = 1'b1;
      if (kind == 1) lcl_mmio_ack = 1'b1;
      else lcl_mmio_dv = 1'b1;
      tick();
      lcl_mmio_ack = 1'b0;
      lcl_mmio_dv  = 1'b0;
      tick();
    end
  endtask

  initial begin
    int kind;
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_lcl_wr", 32'(lcl_mmio_wr), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
    chk("post_rst_wready", 32'(s_axi_wready), 32'd1);
    chk("post_rst_arready", 32'(s_axi_arready), 32'd1);

    // Single write: AW+W in cycle 0, ack in cycle 3
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0010;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("w1_c1_awready", 32'(s_axi_awready), 32'd0);
    chk("w1_c1_lcl_wr", 32'(lcl_mmio_wr), 32'd0);
    tick();
    chk("w1_c2_lcl_wr", 32'(lcl_mmio_wr), 32'd1);
    chk("w1_c2_addr", lcl_mmio_addr, 32'h0000_0010);
    chk("w1_c2_din", lcl_mmio_din, 32'h1234_5678);
    chk("w1_c2_be", 32'(lcl_mmio_be), 32'hF);
    chk("w1_c2_awready", 32'(s_axi_awready), 32'd1);
    tick();
    chk("w1_c3_lcl_wr", 32'(lcl_mmio_wr), 32'd0);
    chk("w1_c3_bvalid", 32'(s_axi_bvalid), 32'd0);
    lcl_mmio_ack = 1'b1; lcl_mmio_rsp = 1'b1;
    tick();
    lcl_mmio_ack = 1'b0;
    chk("w1_c4_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("w1_c4_bresp", 32'(s_axi_bresp), 32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("w1_c5_bvalid", 32'(s_axi_bvalid), 32'd0);

    // W five cycles ahead of AW, bad status, bready stalled for 3 cycles
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'hA5A5_0001; s_axi_wstrb = 4'h3;
    tick();
    s_axi_wvalid = 1'b0;
    chk("w2_wready_full", 32'(s_axi_wready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("w2_no_early_wr", 32'(lcl_mmio_wr), 32'd0);
      tick();
    end
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0044;
    tick();
    s_axi_awvalid = 1'b0;
    chk("w2_c1_lcl_wr", 32'(lcl_mmio_wr), 32'd0);
    tick();
    chk("w2_c2_lcl_wr", 32'(lcl_mmio_wr), 32'd1);
    chk("w2_c2_addr", lcl_mmio_addr, 32'h0000_0044);
    chk("w2_c2_din", lcl_mmio_din, 32'hA5A5_0001);
    chk("w2_c2_be", 32'(lcl_mmio_be), 32'h3);
    tick();
    lcl_mmio_ack = 1'b1; lcl_mmio_rsp = 1'b0;
    tick();
    lcl_mmio_ack = 1'b0;
    chk("w2_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("w2_bresp", 32'(s_axi_bresp), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w2_stall_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("w2_stall_bresp", 32'(s_axi_bresp), 32'h2);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("w2_bvalid_done", 32'(s_axi_bvalid), 32'd0);

    // Read with bad status, dv in cycle 4
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0020;
    tick();
    s_axi_arvalid = 1'b0;
    chk("r1_arready_full", 32'(s_axi_arready), 32'd0);
    tick();
    chk("r1_c2_lcl_rd", 32'(lcl_mmio_rd), 32'd1);
    chk("r1_c2_addr", lcl_mmio_addr, 32'h0000_0020);
    tick();
    chk("r1_c3_rvalid", 32'(s_axi_rvalid), 32'd0);
    tick();
    lcl_mmio_dv = 1'b1; lcl_mmio_dout = 32'hCAFE_F00D; lcl_mmio_rsp = 1'b0;
    tick();
    lcl_mmio_dv = 1'b0; lcl_mmio_dout = 32'd0;
    chk("r1_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("r1_rdata", s_axi_rdata, 32'hCAFE_F00D);
    chk("r1_rresp", 32'(s_axi_rresp), 32'h2);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    chk("r1_rvalid_done", 32'(s_axi_rvalid), 32'd0);

    // Read timeout (TIMEOUT=8): rvalid in cycle 2+8+1
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0030;
    tick();
    s_axi_arvalid = 1'b0;
    tick();
    chk("r2_c2_lcl_rd", 32'(lcl_mmio_rd), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("r2_wait_rvalid", 32'(s_axi_rvalid), 32'd0);
    end
    tick();
    chk("r2_tmo_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("r2_tmo_rresp", 32'(s_axi_rresp), 32'h2);
    chk("r2_tmo_rdata", s_axi_rdata, 32'hDEAD_BEEF);
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    chk("r2_rvalid_done", 32'(s_axi_rvalid), 32'd0);
    lcl_mmio_dv = 1'b1; lcl_mmio_dout = 32'h1111_2222; lcl_mmio_rsp = 1'b1;
    tick();
    lcl_mmio_dv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("r2_late_dv_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("r2_late_dv_rdata", s_axi_rdata, 32'hDEAD_BEEF);
      tick();
    end

    // Arbitration: AW, W, AR continuously pending -> W, R, W, R
    do_reset();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0100;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h0000_00AA; s_axi_wstrb = 4'hF;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0200;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(kind);
      chk("arb_order", 32'(kind), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;

    // Reset during WR_WAIT
    do_reset();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0050;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h7777_8888; s_axi_wstrb = 4'hC;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    tick();
    chk("rw_c2_lcl_wr", 32'(lcl_mmio_wr), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rw_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rw_awready", 32'(s_axi_awready), 32'd0);
    chk("rw_wready", 32'(s_axi_wready), 32'd0);
    chk("rw_addr", lcl_mmio_addr, 32'd0);
    chk("rw_din", lcl_mmio_din, 32'd0);
    chk("rw_be", 32'(lcl_mmio_be), 32'd0);
    rst = 1'b0;
    lcl_mmio_ack = 1'b1; lcl_mmio_rsp = 1'b1;
    tick();
    lcl_mmio_ack = 1'b0;
    chk("rw_late_ack_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rw_awready_back", 32'(s_axi_awready), 32'd1);
    chk("rw_arready_back", 32'(s_axi_arready), 32'd1);
    tick();
    chk("rw_no_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rw_no_lcl_wr", 32'(lcl_mmio_wr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
